// File: rtl/dot_fp_pack.sv
// dot_fp_pack: converts a signed fixed-point dot-product sum into a packed
// minifloat {sign, exponent, mantissa}. Three-stage pipeline:
// sign/magnitude capture, leading-one normalize, round/saturate/pack.
module dot_fp_pack #(
    parameter int exp_width = 5,
    parameter int man_width = 2,
    parameter int k = 32,
    parameter bit e4m3_spec = (exp_width == 4) && (man_width == 3),
    localparam int bit_width = 1 + exp_width + man_width,
    localparam int bias = (1 << (exp_width - 1)) - 1,
    localparam int frac_width = 2 * (bias - 1 + man_width),
    localparam int prd_width = 2 * ((1 << exp_width) + man_width),
    localparam int in_width = prd_width + $clog2(k)
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic                 i_valid,
    output logic                 o_ready,
    input  logic [in_width-1:0]  i_dp,
    input  logic                 i_nan,
    output logic                 o_valid,
    input  logic                 i_ready,
    output logic [bit_width-1:0] o_fp
);

    localparam int MAG_W = in_width + 1;
    localparam int EXT_W = MAG_W + 1;
    // kept significand (man_width+1 bits) plus one guard bit
    localparam int KW = man_width + 2;
    // bit position of the subnormal LSB inside the magnitude
    localparam int U_MIN = frac_width + 1 - bias - man_width;
    localparam int MAX_EXP = e4m3_spec ? (1 << exp_width) - 1 : (1 << exp_width) - 2;
    localparam int MAX_MAN = e4m3_spec ? (1 << man_width) - 2 : (1 << man_width) - 1;

    // Round to nearest even: guard is kg[0], LSB of the kept value is kg[1].
    function automatic logic [KW-1:0] round_rne(logic [KW-1:0] kg, logic sticky);
        logic [KW-1:0] kept;
        kept = {1'b0, kg[KW-1:1]};
        return kept + KW'(kg[0] && (sticky || kg[1]));
    endfunction

    // Turn a rounded significand into exponent/mantissa fields and clamp
    // anything beyond the largest finite encoding.
    function automatic logic [bit_width-1:0] pack_sat(logic sign, int ebase, logic [KW-1:0] kr);
        int e;
        logic [man_width-1:0] man;
        if (kr[KW-1]) begin
            e = ebase + 2;
            man = '0;
        end else if (kr[man_width]) begin
            e = ebase + 1;
            man = kr[man_width-1:0];
        end else begin
            e = 0;
            man = kr[man_width-1:0];
        end
        if (e > MAX_EXP || (e == MAX_EXP && int'(man) > MAX_MAN)) begin
            e = MAX_EXP;
            man = man_width'(MAX_MAN);
        end
        return {sign, exp_width'(e), man};
    endfunction

    logic en;
    assign en = !o_valid || i_ready;
    assign o_ready = en;

    // ---- stage 1: sign / magnitude / nan ----
    logic signed [MAG_W-1:0] dp_ext;
    logic [MAG_W-1:0] mag_in;
    assign dp_ext = MAG_W'($signed(i_dp));
    assign mag_in = i_dp[in_width-1] ? unsigned'(-dp_ext) : unsigned'(dp_ext);

    logic vld_p1, sign_p1, nan_p1;
    logic [MAG_W-1:0] mag_p1;

    // ---- stage 2: leading-one detect and normalize shift ----
    int lead, shift;
    logic [EXT_W-1:0] ext, low_mask;
    logic [KW-1:0] kg_c;
    logic sticky_c;

    // Locate the leading one and derive the right shift that keeps
    // man_width bits below it, clamped at the subnormal quantum.
    always_comb begin
        lead = 0;
        for (int b = 0; b < MAG_W; b++) begin
            if (mag_p1[b]) lead = b;
        end
        shift = (lead - man_width > U_MIN) ? lead - man_width : U_MIN;
        ext = {mag_p1, 1'b0};
        low_mask = (EXT_W'(1) << shift) - EXT_W'(1);
        kg_c = KW'(ext >> shift);
        sticky_c = |(ext & low_mask);
    end

    logic vld_p2, sign_p2, nan_p2, zero_p2, sticky_p2;
    logic [KW-1:0] kg_p2;
    int ebase_p2;

    // ---- stage 3: round, saturate, pack ----
    logic [bit_width-1:0] result;

    // Specials take priority over the numeric encoding.
    always_comb begin
        result = '0;
        if (nan_p2) result = {1'b0, {exp_width{1'b1}}, {man_width{1'b1}}};
        else if (zero_p2) result = '0;
        else result = pack_sat(sign_p2, ebase_p2, round_rne(kg_p2, sticky_p2));
    end

    // Valid chain and output register; cleared asynchronously so nothing
    // in flight survives a reset.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            vld_p1 <= 1'b0;
            vld_p2 <= 1'b0;
            o_valid <= 1'b0;
            o_fp <= '0;
        end else if (en) begin
            vld_p1 <= i_valid;
            vld_p2 <= vld_p1;
            o_valid <= vld_p2;
            o_fp <= vld_p2 ? result : '0;
        end
    end

    // Data registers advance with the pipeline and carry no reset.
    always_ff @(posedge i_clk) begin
        if (en) begin
            sign_p1 <= i_dp[in_width-1];
            mag_p1 <= mag_in;
            nan_p1 <= i_nan;
            sign_p2 <= sign_p1;
            nan_p2 <= nan_p1;
            zero_p2 <= (mag_p1 == '0);
            kg_p2 <= kg_c;
            sticky_p2 <= sticky_c;
            ebase_p2 <= shift - U_MIN;
        end
    end

endmodule
